// File: rtl/sm_shift_add_mult_if.sv
// Handshake and operand/result bundle for the sign-magnitude shift-add multiplier.
// master drives start and operands; slave returns product, sign, busy and done.
interface sm_shift_add_mult_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a_mag;
  logic               a_sign;
  logic [WIDTH-1:0]   b_mag;
  logic               b_sign;
  logic [2*WIDTH-1:0] product;
  logic               product_sign;
  logic               busy;
  logic               done;

  modport master (
    output start, a_mag, a_sign, b_mag, b_sign,
    input  product, product_sign, busy, done
  );

  modport slave (
    input  start, a_mag, a_sign, b_mag, b_sign,
    output product, product_sign, busy, done
  );
endinterface

// File: rtl/sm_shift_add_mult.sv
// Sequential sign-magnitude add-and-shift multiplier; done pulses 17 cycles after start is accepted.
// No backpressure: start is taken only in IDLE, requests arriving while busy or in DONE are dropped.
module sm_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  sm_shift_add_mult_if.slave bus
);
  localparam int SC_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic             e_reg;
  logic [SC_W-1:0]  sc;
  logic             s_reg;
  logic             last_iter;
  logic             busy_int;
  logic             done_int;

  assign last_iter = (sc == SC_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_int  = 1'b0;
    done_int  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = ADD;
        end
      end
      ADD: begin
        busy_int  = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        busy_int  = 1'b1;
        state_nxt = last_iter ? DONE : ADD;
      end
      DONE: begin
        done_int  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // E is always clear entering ADD, so a single carry bit covers the sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_reg <= '0;
      a_reg <= '0;
      q_reg <= '0;
      e_reg <= 1'b0;
      sc    <= '0;
      s_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            b_reg <= bus.a_mag;
            q_reg <= bus.b_mag;
            a_reg <= '0;
            e_reg <= 1'b0;
            sc    <= '0;
            s_reg <= bus.a_sign ^ bus.b_sign;
          end
        end
        ADD: begin
          if (q_reg[0]) begin
            {e_reg, a_reg} <= {1'b0, a_reg} + {1'b0, b_reg};
          end
        end
        SHIFT: begin
          {e_reg, a_reg, q_reg} <= {1'b0, e_reg, a_reg, q_reg[WIDTH-1:1]};
          sc                    <= sc + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.product      = {a_reg, q_reg};
  assign bus.product_sign = s_reg & (|{a_reg, q_reg});
  assign bus.busy         = busy_int;
  assign bus.done         = done_int;
endmodule

// File: doc/sm_shift_add_mult.md
# sm_shift_add_mult

Sequential sign-magnitude multiplier for the Q2 arithmetic unit. It captures two WIDTH-bit magnitudes with separate sign bits and runs a classic add-and-shift loop over an accumulator A, a carry bit E and a multiplier register Q. The result is a 2·WIDTH-bit magnitude plus a sign bit. A small FSM sequences the load, add and shift steps that the unit's 8-bit registers perform, and gives the surrounding logic a start/busy/done handshake.

## Interface
- WIDTH, 8, operand magnitude width; iteration counter is ceil(log2(WIDTH+1)) bits
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  request a multiplication; sampled only in IDLE
- a_mag  in  WIDTH  multiplicand magnitude
- a_sign  in  1  multiplicand sign (1 = negative)
- b_mag  in  WIDTH  multiplier magnitude
- b_sign  in  1  multiplier sign
- product  out  2·WIDTH  result magnitude, {A,Q}
- product_sign  out  1  result sign
- busy  out  1  high while an operation is in progress (ADD/SHIFT states)
- done  out  1  one-cycle pulse when product is valid

## Operation
- Internal registers:
  - B (multiplicand)
  - A (accumulator)
  - E (carry)
  - Q (multiplier, shifts to become the product low half)
  - SC (iteration counter)
  - S (sign)
- FSM states are IDLE, ADD, SHIFT and DONE.
- IDLE, on start=1:
  - B←a_mag, Q←b_mag, A←0, E←0, SC←0, S←a_sign^b_sign.
  - Go to ADD.
  - With start=0, stay in IDLE and hold all registers.
- ADD:
  - If Q[0]=1, {E,A}←A+B (WIDTH+1-bit sum, carry into E). Otherwise A and E hold.
  - Go to SHIFT.
- SHIFT:
  - {E,A,Q}←{1'b0,E,A,Q[WIDTH-1:1]} (logical right shift, E cleared), SC←SC+1.
  - If SC+1=WIDTH, go to DONE; otherwise go to ADD.
- DONE: go to IDLE unconditionally.
- Outputs:
  - product={A,Q} at all times. It is stable and valid from DONE until the next accepted start.
  - product_sign=S, except it is forced to 0 when {A,Q}=0. Negative zero is never produced.
  - busy=1 in ADD and SHIFT only.
  - done=1 in DONE only.
- start is ignored in ADD, SHIFT and DONE. No queuing; a start during an operation is dropped.
- Operand inputs only need to be stable at the accepting edge.
- Width rules:
  - Maximum result (2^WIDTH−1)^2 fits in 2·WIDTH bits.
  - E never carries beyond one bit.
  - No overflow is possible.

## Timing
- Reset (reset=0, asynchronous):
  - State=IDLE, A=B=Q=0, E=0, SC=0, S=0.
  - product=0, product_sign=0, busy=0, done=0.
- A reset during an operation aborts it immediately. The result is discarded, with no done pulse.
- Start accepted at edge k:
  - busy=1 from edge k to edge k+16.
  - State is DONE after edge k+16, so done=1 for the single cycle between edges k+16 and k+17.
  - IDLE after edge k+17.
- Latency is 17 cycles from the accepting edge to done. With start held high, throughput is one result per 18 cycles.
- If start is held high continuously, the next operation is accepted at the first edge in IDLE (edge k+18), using the operand values present then.
- Release of reset has no effect on other inputs within the same cycle. The first start can be accepted at the first rising edge with reset=1.

## Test plan
- Basic: a=13 (+), b=11 (−), start for one cycle -> 17 cycles later done=1, product=0x008F, product_sign=1, busy high for exactly 16 cycles.
- Max operands: a=255 (−), b=255 (−) -> product=0xFE01, product_sign=0. E carries on the intermediate adds and the final result has no overflow.
- Zero: a=0 (+), b=5 (−) -> product=0x0000 with product_sign=0 (negative zero suppressed). Also a=200, b=0 -> product=0, and A is never updated.
- Start ignored while busy: start 7×9, then pulse start with a=1, b=1 at cycle 5 -> product=63, exactly one done pulse, second request dropped.
- Reset mid-op: start 100×100, assert reset=0 asynchronously (between edges) at cycle 8 -> outputs 0 immediately, no done pulse. After release, 3×4 yields product=12.
- Back-to-back: hold start=1 with 6×7 then 15×15 -> done pulses 18 cycles apart, product=42 then 225, product holds between the pulses.
